// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared state type and length helper for the sequence detector
package seqdet_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  // A zero or oversized length means "use the whole pattern register".
  function automatic int unsigned len_clamp(input int unsigned len, input int unsigned maxlen);
    return ((len == 0) || (len > maxlen)) ? maxlen : len;
  endfunction

endpackage

// File: rtl/seqdet_shift_match.sv
// rtl/seqdet_shift_match.sv - bit history, fill counter and length-masked pattern compare
module seqdet_shift_match
  import seqdet_pkg::*;
#(
  parameter int MAXLEN = 8,
  parameter int LENW   = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              shift,
  input  logic              bit_in,
  input  logic [LENW-1:0]   len,
  input  logic [MAXLEN-1:0] pattern,
  input  logic              overlap,
  output logic              match
);

  logic [MAXLEN-1:0] r_hist;
  logic [LENW-1:0]   r_fill;
  logic [MAXLEN-1:0] w_hist_next;
  logic [MAXLEN-1:0] w_mask;
  logic [LENW-1:0]   w_fill_next;

  always_comb begin
    w_hist_next = {r_hist[MAXLEN-2:0], bit_in};
    w_fill_next = (r_fill >= len) ? len : r_fill + 1'b1;
    for (int i = 0; i < MAXLEN; i++) begin
      w_mask[i] = (i < int'(len));
    end
  end

  // Predicts a hit for bit_in as if it were shifted; the top decides whether to commit it.
  assign match = (w_fill_next == len) && ((w_hist_next & w_mask) == (pattern & w_mask));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (shift) begin
      if (match && !overlap) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_hist_next;
        r_fill <= w_fill_next;
      end
    end
  end

endmodule

// File: rtl/seqdet_ctrl.sv
// rtl/seqdet_ctrl.sv - run controller: config latch, FSM, stream/event handshakes, match counter
module seqdet_ctrl
  import seqdet_pkg::*;
#(
  parameter  int MAXLEN = 8,
  parameter  int CNTW   = 16,
  localparam int LENW   = $clog2(MAXLEN + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LENW-1:0]   cfg_len,
  input  logic              cfg_overlap,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              match_valid,
  input  logic              match_ready,
  output logic [CNTW-1:0]   match_count,
  output logic              busy
);

  state_t            r_state;
  state_t            w_state_next;
  logic [MAXLEN-1:0] r_pattern;
  logic [LENW-1:0]   r_len;
  logic              r_overlap;
  logic [CNTW-1:0]   r_count;
  logic              r_stop_pend;

  logic w_go;
  logic w_accept;
  logic w_match;
  logic w_hit;
  logic w_shift;

  assign w_go     = (r_state == IDLE) && start && !stop;
  assign w_accept = (r_state == RUN) && in_valid;
  assign w_hit    = w_accept && w_match;
  // A bit taken alongside a non-matching stop is consumed but never enters the history.
  assign w_shift  = w_accept && (w_hit || !stop);

  seqdet_shift_match #(
    .MAXLEN (MAXLEN),
    .LENW   (LENW)
  ) u_shift_match (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (w_go),
    .shift   (w_shift),
    .bit_in  (in_bit),
    .len     (r_len),
    .pattern (r_pattern),
    .overlap (r_overlap),
    .match   (w_match)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    match_valid  = 1'b0;
    busy         = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_go) w_state_next = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (w_hit)     w_state_next = REPORT;
        else if (stop) w_state_next = IDLE;
      end
      REPORT: begin
        match_valid = 1'b1;
        if (match_ready) w_state_next = (r_stop_pend || stop) ? IDLE : RUN;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pattern   <= '0;
      r_len       <= LENW'(MAXLEN);
      r_overlap   <= 1'b0;
      r_count     <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      if ((r_state == IDLE) && cfg_we) begin
        r_pattern <= cfg_pattern;
        r_len     <= LENW'(len_clamp(32'(cfg_len), MAXLEN));
        r_overlap <= cfg_overlap;
      end
      if (w_go) begin
        r_count     <= '0;
        r_stop_pend <= 1'b0;
      end else begin
        if (w_hit && !(&r_count)) r_count <= r_count + 1'b1;
        if (w_hit && stop) begin
          r_stop_pend <= 1'b1;
        end else if (r_state == REPORT) begin
          if (match_ready) r_stop_pend <= 1'b0;
          else if (stop)   r_stop_pend <= 1'b1;
        end
      end
    end
  end

  assign match_count = r_count;

endmodule

// File: tb/tb_seqdet_ctrl.sv
// tb/tb_seqdet_ctrl.sv - scoreboard bench for seqdet_ctrl with directed streams
module tb_seqdet_ctrl;

  localparam int MAXLEN = 8;
  localparam int CNTW   = 2;
  localparam int LENW   = $clog2(MAXLEN + 1);

  logic              clk = 1'b0;
  logic              rstn;
  logic              cfg_we;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LENW-1:0]   cfg_len;
  logic              cfg_overlap;
  logic              start;
  logic              stop;
  logic              in_valid;
  logic              in_bit;
  logic              in_ready;
  logic              match_valid;
  logic              match_ready;
  logic [CNTW-1:0]   match_count;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  seqdet_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .start       (start),
    .stop        (stop),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .in_ready    (in_ready),
    .match_valid (match_valid),
    .match_ready (match_ready),
    .match_count (match_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Each event handshake pops the count the stimulus predicted for it.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rstn && match_valid && match_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_match: got event with count %0d expected none at %0t", match_count, $time);
        end else begin
          check("event_count", int'(match_count), exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [MAXLEN-1:0] pat, input int len, input logic ovl);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = LENW'(len); cfg_overlap = ovl;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic with_stop);
    int waited = 0;
    in_valid = 1'b1; in_bit = b; stop = with_stop;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 at %0t", $time);
    end
    step();
    in_valid = 1'b0; stop = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] bits, input int n, input int hit_idx, input int hit_cnt);
    for (int i = 0; i < n; i++) begin
      if (i == hit_idx) exp_q.push_back(hit_cnt);
      send_bit(bits[n-1-i], 1'b0);
    end
  endtask

  task automatic settle();
    repeat (3) step();
  endtask

  initial begin : stim
    int waited;
    rstn = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_bit = 1'b0; match_ready = 1'b1;
    step();
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_match_valid", int'(match_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(match_count), 0);
    step();
    rstn = 1'b1;
    step();

    // 1: 0110 non-overlap, stream 0110110 -> one match
    do_cfg(8'b0110, 4, 1'b0);
    do_start();
    @(negedge clk);
    check("t1_busy", int'(busy), 1);
    check("t1_in_ready", int'(in_ready), 1);
    step();
    send_bits(8'b0110110, 7, 3, 1);
    settle();
    check("t1_count", int'(match_count), 1);

    // 2: overlap -> matches after bits 4 and 7
    do_stop();
    do_cfg(8'b0110, 4, 1'b1);
    do_start();
    send_bits(8'b0110110, 7, 3, 1);
    exp_q.push_back(2);
    settle();
    check("t2_count", int'(match_count), 2);

    // stop with a non-matching bit: return to IDLE, counter kept
    send_bits(8'b011, 3, -1, 0);
    send_bit(1'b1, 1'b1);
    settle();
    check("t2_stop_busy", int'(busy), 0);
    check("t2_stop_count", int'(match_count), 2);

    // 3: consumer stalls 5 cycles; stream held off, next bits still land
    do_cfg(8'b0110, 4, 1'b0);
    do_start();
    send_bits(8'b011, 3, -1, 0);
    match_ready = 1'b0;
    exp_q.push_back(1);
    send_bit(1'b0, 1'b0);
    in_valid = 1'b1; in_bit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        step();
        match_ready = 1'b1;
      end
      @(negedge clk);
      check("t3_valid_held", int'(match_valid), 1);
      check("t3_ready_low", int'(in_ready), 0);
    end
    send_bits(8'b0110, 4, 3, 2);
    settle();
    check("t3_count", int'(match_count), 2);

    // 4: stop coincident with the match
    do_stop();
    do_start();
    send_bits(8'b011, 3, -1, 0);
    exp_q.push_back(1);
    send_bit(1'b0, 1'b1);
    settle();
    check("t4_busy", int'(busy), 0);
    check("t4_in_ready", int'(in_ready), 0);
    check("t4_count", int'(match_count), 1);

    // 5: config writes during RUN are ignored; len 0 means full width
    do_start();
    do_cfg(8'b1111, 4, 1'b0);
    send_bits(8'b0110, 4, 3, 1);
    send_bits(8'b1111, 4, -1, 0);
    settle();
    check("t5_cfg_ignored", int'(match_count), 1);
    do_stop();
    do_cfg(8'hB3, 0, 1'b0);
    do_start();
    send_bits(8'hB3, 8, 7, 1);
    settle();
    check("t5_len_max", int'(match_count), 1);

    // 6: counter saturates, then reset while an event is pending
    do_stop();
    do_cfg(8'b01, 2, 1'b0);
    do_start();
    for (int k = 1; k <= 5; k++) send_bits(8'b01, 2, 1, (k > 3) ? 3 : k);
    settle();
    check("t6_saturate", int'(match_count), 3);
    send_bit(1'b0, 1'b0);
    match_ready = 1'b0;
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    check("t6_pending", int'(match_valid), 1);
    step();
    rstn = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", int'(match_valid), 0);
    check("t6_rst_ready", int'(in_ready), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_count", int'(match_count), 0);
    step();
    rstn = 1'b1;
    match_ready = 1'b1;
    step();

    // reset config is pattern 0, full length: eight zeros match once
    do_start();
    send_bits(8'h00, 8, 7, 1);
    settle();
    check("t6_post_rst_count", int'(match_count), 1);

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      waited++;
      step();
    end
    check("events_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
